// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32 opcode constants, forwarding selects and the
//               ID/EX state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] OP     = 7'b0110011;

    typedef enum logic [1:0] {
        REGISTER = 2'd0,
        ALU_1    = 2'd1,
        ALU_2    = 2'd2,
        MEM      = 2'd3
    } fwd_src_t;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    // Opcodes whose second ALU operand is the immediate rather than rs2.
    function automatic logic uses_imm(input logic [6:0] opcode);
        return (opcode == OP_IMM) || (opcode == LOAD) || (opcode == STORE) ||
               (opcode == LUI)    || (opcode == JAL);
    endfunction

    // After a bubble the ALU producer has moved to MEM, so alu_1 becomes mem.
    function automatic fwd_src_t remap_src(input fwd_src_t src);
        return (src == ALU_1) ? MEM : src;
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_operand_stage_operand_mux.sv
// ============================================================================
// Module      : operand_mux
// Description : 4:1 forwarding mux selecting one EX operand source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_mux
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  fwd_src_t          sel,
    input  logic [XLEN-1:0]   reg_data,
    input  logic [XLEN-1:0]   alu_1_data,
    input  logic [XLEN-1:0]   alu_2_data,
    input  logic [XLEN-1:0]   mem_data,
    output logic [XLEN-1:0]   data
);

    always_comb begin
        data = reg_data;
        case (sel)
            ALU_1:   data = alu_1_data;
            ALU_2:   data = alu_2_data;
            MEM:     data = mem_data;
            default: data = reg_data;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
// ============================================================================
// Module      : id_ex_operand_stage
// Description : ID/EX register with operand forwarding, load-use bubble
//               insertion and branch flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_operand_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [6:0]        id_opcode,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [1:0]        rs1_src,
    input  logic [1:0]        rs2_src,
    input  logic              busy,
    input  logic              invalid,
    input  logic [XLEN-1:0]   alu_1_result,
    input  logic [XLEN-1:0]   alu_2_result,
    input  logic [XLEN-1:0]   mem_data,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [6:0]        ex_opcode,
    output logic [REG_W-1:0]  ex_rd,
    output logic [XLEN-1:0]   ex_op_a,
    output logic [XLEN-1:0]   ex_op_b,
    output logic [XLEN-1:0]   ex_store_data,
    output logic              stall_if,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_next;

    logic [XLEN-1:0]    r_hold_pc;
    logic [6:0]         r_hold_opcode;
    logic [REG_W-1:0]   r_hold_rd;
    logic [XLEN-1:0]    r_hold_rs1;
    logic [XLEN-1:0]    r_hold_rs2;
    logic [XLEN-1:0]    r_hold_imm;
    logic               r_hold_invalid;
    fwd_src_t           r_hold_rs1_src;
    fwd_src_t           r_hold_rs2_src;

    logic               w_bubble;
    logic               w_stall_start;
    logic [XLEN-1:0]    w_pc;
    logic [6:0]         w_opcode;
    logic [REG_W-1:0]   w_rd;
    logic [XLEN-1:0]    w_rs1;
    logic [XLEN-1:0]    w_rs2;
    logic [XLEN-1:0]    w_imm;
    logic               w_invalid;
    fwd_src_t           w_rs1_src;
    fwd_src_t           w_rs2_src;
    logic [XLEN-1:0]    w_rs1_fwd;
    logic [XLEN-1:0]    w_rs2_fwd;
    logic [XLEN-1:0]    w_op_a;
    logic [XLEN-1:0]    w_op_b;

    assign w_bubble      = (r_state == BUBBLE);
    assign w_stall_start = (r_state == RUN) && id_valid && busy && !flush;
    assign stall_if      = reset_n && w_stall_start;

    // During the bubble cycle the held copy replaces the live ID fields.
    assign w_pc      = w_bubble ? r_hold_pc      : id_pc;
    assign w_opcode  = w_bubble ? r_hold_opcode  : id_opcode;
    assign w_rd      = w_bubble ? r_hold_rd      : id_rd;
    assign w_rs1     = w_bubble ? r_hold_rs1     : id_rs1_data;
    assign w_rs2     = w_bubble ? r_hold_rs2     : id_rs2_data;
    assign w_imm     = w_bubble ? r_hold_imm     : id_imm;
    assign w_invalid = w_bubble ? r_hold_invalid : invalid;
    assign w_rs1_src = w_bubble ? r_hold_rs1_src : fwd_src_t'(rs1_src);
    assign w_rs2_src = w_bubble ? r_hold_rs2_src : fwd_src_t'(rs2_src);

    operand_mux #(.XLEN(XLEN)) u_rs1_mux (
        .sel        (w_rs1_src),
        .reg_data   (w_rs1),
        .alu_1_data (alu_1_result),
        .alu_2_data (alu_2_result),
        .mem_data   (mem_data),
        .data       (w_rs1_fwd)
    );

    operand_mux #(.XLEN(XLEN)) u_rs2_mux (
        .sel        (w_rs2_src),
        .reg_data   (w_rs2),
        .alu_1_data (alu_1_result),
        .alu_2_data (alu_2_result),
        .mem_data   (mem_data),
        .data       (w_rs2_fwd)
    );

    always_comb begin
        w_op_a = w_rs1_fwd;
        if (w_opcode == LUI) begin
            w_op_a = '0;
        end else if (w_opcode == JAL) begin
            w_op_a = w_pc;
        end
        w_op_b = (uses_imm(w_opcode) || w_invalid) ? w_imm : w_rs2_fwd;
    end

    // A flush or a completed bubble always lands back in RUN.
    always_comb begin
        w_state_next = RUN;
        if (w_stall_start) begin
            w_state_next = BUBBLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= RUN;
            r_hold_pc      <= '0;
            r_hold_opcode  <= '0;
            r_hold_rd      <= '0;
            r_hold_rs1     <= '0;
            r_hold_rs2     <= '0;
            r_hold_imm     <= '0;
            r_hold_invalid <= 1'b0;
            r_hold_rs1_src <= REGISTER;
            r_hold_rs2_src <= REGISTER;
            ex_valid       <= 1'b0;
            ex_pc          <= '0;
            ex_opcode      <= '0;
            ex_rd          <= '0;
            ex_op_a        <= '0;
            ex_op_b        <= '0;
            ex_store_data  <= '0;
            stall_cnt      <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_stall_start) begin
                ex_valid       <= 1'b0;
                r_hold_pc      <= id_pc;
                r_hold_opcode  <= id_opcode;
                r_hold_rd      <= id_rd;
                r_hold_rs1     <= id_rs1_data;
                r_hold_rs2     <= id_rs2_data;
                r_hold_imm     <= id_imm;
                r_hold_invalid <= invalid;
                r_hold_rs1_src <= remap_src(fwd_src_t'(rs1_src));
                r_hold_rs2_src <= remap_src(fwd_src_t'(rs2_src));
                if (stall_cnt != '1) begin
                    stall_cnt <= stall_cnt + c_cnt_one;
                end
            end else begin
                ex_valid      <= (w_bubble || id_valid) && !flush;
                ex_pc         <= w_pc;
                ex_opcode     <= w_opcode;
                ex_rd         <= w_rd;
                ex_op_a       <= w_op_a;
                ex_op_b       <= w_op_b;
                ex_store_data <= w_rs2_fwd;
            end
        end
    end

endmodule

`default_nettype wire
